// File: rtl/obi_pkg.sv
// Shared OBI bus types used by the external-slave memory model and its bench.
// obi_req_t  : manager -> slave request (req, we, be, addr, wdata).
// obi_resp_t : slave -> manager response (gnt, rvalid, rdata).
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/ext_obi_latency_mem_checker.sv
// Simulation assertions for ext_obi_latency_mem.
// Ports: clk_i, rst_ni, count_i (outstanding count), pop_i (response issued).
module ext_obi_latency_mem_checker #(
  parameter int unsigned LATENCY         = 2,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_W           = 3
) (
  input logic             clk_i,
  input logic             rst_ni,
  input logic [CNT_W-1:0] count_i,
  input logic             pop_i
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  // Parameter legality and queue occupancy invariants.
  always_ff @(posedge clk_i) begin
    assert (LATENCY >= 1) else $error("LATENCY must be at least 1");
    assert (MAX_OUTSTANDING >= 1) else $error("MAX_OUTSTANDING must be at least 1");
    if (rst_ni) begin
      assert (count_i <= MAX_CNT) else $error("outstanding count above limit");
      assert (!(pop_i && (count_i == '0))) else $error("response issued from empty queue");
    end
  end

endmodule

// File: rtl/obi_resp_queue.sv
// In-order response queue with a per-entry latency countdown.
// Ports:
//   clk_i, rst_ni   : clock, synchronous active-low reset (drops all entries)
//   push_i          : enqueue push_data_i with countdown INIT_CNT
//   push_data_i     : response data to enqueue
//   pop_o           : head entry is valid and its countdown reached zero;
//                     the head leaves the queue in this same cycle
//   head_data_o     : data of the head entry
//   count_o         : number of entries currently held
module obi_resp_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned INIT_CNT = 1,
  parameter int unsigned DATA_W   = 32,
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CD_W    = (INIT_CNT > 0) ? $clog2(INIT_CNT + 1) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  output logic              pop_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [CD_W-1:0]   cd_q [DEPTH];
  logic [CD_W-1:0]   cd_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              pop_s;

  // Circular pointer increment; DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign pop_s       = valid_q[rd_ptr_q] && (cd_q[rd_ptr_q] == '0);
  assign pop_o       = pop_s;
  assign head_data_o = data_q[rd_ptr_q];
  assign count_o     = count_q;

  // Next state: age all waiting entries, retire the head, append a new entry.
  always_comb begin
    valid_d  = valid_q;
    cd_d     = cd_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (cd_q[i] != '0)) begin
        cd_d[i] = cd_q[i] - CD_W'(1);
      end else begin
        cd_d[i] = cd_q[i];
      end
    end
    if (pop_s) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    // The grant logic never pushes into a full queue, so the write slot is
    // never the entry being retired.
    if (push_i) begin
      valid_d[wr_ptr_q] = 1'b1;
      cd_d[wr_ptr_q]    = CD_W'(INIT_CNT);
      wr_ptr_d          = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    case ({push_i, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        cd_q[i] <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cd_q     <= cd_d;
    end
  end

  // Payload storage; only meaningful while the matching valid bit is set.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      data_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/ext_obi_latency_mem.sv
// OBI slave memory model with fixed grant-to-response latency, a bounded
// number of outstanding transactions and a bench-controlled grant stall.
// Ports:
//   clk_i, rst_ni   : clock, synchronous active-low reset (store keeps data)
//   stall_i         : forces gnt low while high; queued responses still drain
//   slave_req_i     : OBI request
//   slave_resp_o    : OBI response (gnt combinational from req)
//   outstanding_o   : granted-but-unanswered transaction count
module ext_obi_latency_mem
  import obi_pkg::*;
#(
  parameter int unsigned NUM_WORDS       = 1024,
  parameter int unsigned LATENCY         = 2,
  parameter int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             stall_i,
  input  obi_req_t         slave_req_i,
  output obi_resp_t        slave_resp_o,
  output logic [CNT_W-1:0] outstanding_o
);

  localparam int unsigned      AW      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [31:0]      mem_q [NUM_WORDS];
  logic [AW-1:0]    idx_s;
  logic [CNT_W-1:0] count_s;
  logic             gnt_s;
  logic             accept_s;
  logic             pop_s;
  logic [31:0]      push_data_s;
  logic [31:0]      head_data_s;
  logic             unused_addr_s;

  // Only the word index bits select storage; the rest of the address aliases.
  assign unused_addr_s = ^slave_req_i.addr;

  // Grant, accept and the data captured into the response queue.
  always_comb begin
    idx_s = slave_req_i.addr[2 +: AW];
    // A full queue blocks the grant even when the head retires this cycle.
    gnt_s = rst_ni & slave_req_i.req & ~stall_i & (count_s < MAX_CNT);
    accept_s = slave_req_i.req & gnt_s;
    if (slave_req_i.we) begin
      push_data_s = 32'h0;
    end else begin
      push_data_s = mem_q[idx_s];
    end
  end

  // Backing store: byte-enable merge on write accept, never reset.
  always_ff @(posedge clk_i) begin
    if (accept_s && slave_req_i.we) begin
      for (int k = 0; k < 4; k++) begin
        if (slave_req_i.be[k]) begin
          mem_q[idx_s][8*k +: 8] <= slave_req_i.wdata[8*k +: 8];
        end
      end
    end
  end

  obi_resp_queue #(
    .DEPTH    (MAX_OUTSTANDING),
    .INIT_CNT (LATENCY - 1),
    .DATA_W   (32)
  ) u_queue (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (accept_s),
    .push_data_i (push_data_s),
    .pop_o       (pop_s),
    .head_data_o (head_data_s),
    .count_o     (count_s)
  );

  // Response bus: rdata is held at zero whenever rvalid is low.
  always_comb begin
    slave_resp_o.gnt    = gnt_s;
    slave_resp_o.rvalid = pop_s;
    if (pop_s) begin
      slave_resp_o.rdata = head_data_s;
    end else begin
      slave_resp_o.rdata = 32'h0;
    end
    outstanding_o = count_s;
  end

  ext_obi_latency_mem_checker #(
    .LATENCY         (LATENCY),
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CNT_W           (CNT_W)
  ) u_checker (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .count_i (count_s),
    .pop_i   (pop_s)
  );

endmodule
